// File: rtl/vga_timing_ctrl.sv
// 640x480@60 VGA timing master: raster counters, renderer request,
// latency-matched sync/enable delay line and registered pin outputs.
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIX_LAT  = 1
) (
  input  logic        vga_clk,
  input  logic        vga_rst,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        de_req,
  output logic        frame_start,
  input  logic [11:0] pixel_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } tim_t;

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        active, hs_act, vs_act;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        fs_q, fs_d;
  tim_t        s1_q, s1_d;
  tim_t        dly_q [PIX_LAT];
  tim_t        tap;
  logic [11:0] rgb_q, rgb_d;
  logic        de_o_q;
  logic        hs_o_q, hs_o_d;
  logic        vs_o_q, vs_o_d;

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end
  end

  assign active = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign hs_act = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
  assign vs_act = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

  // Tap sits PIX_LAT clocks behind the request, matching pixel_data.
  always_comb begin
    s1_d   = '{de: active, hs: hs_act, vs: vs_act};
    x_d    = active ? h_cnt_q : '0;
    y_d    = active ? v_cnt_q : '0;
    fs_d   = (h_cnt_q == '0) && (v_cnt_q == '0);
    tap    = dly_q[PIX_LAT-1];
    rgb_d  = tap.de ? pixel_data : '0;
    hs_o_d = tap.hs ? SYNC_POL : ~SYNC_POL;
    vs_o_d = tap.vs ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
      s1_q    <= '0;
      for (int i = 0; i < PIX_LAT; i++) dly_q[i] <= '0;
      rgb_q   <= '0;
      de_o_q  <= 1'b0;
      hs_o_q  <= ~SYNC_POL;
      vs_o_q  <= ~SYNC_POL;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fs_q    <= fs_d;
      s1_q    <= s1_d;
      dly_q[0] <= s1_q;
      for (int i = 1; i < PIX_LAT; i++) dly_q[i] <= dly_q[i-1];
      rgb_q   <= rgb_d;
      de_o_q  <= tap.de;
      hs_o_q  <= hs_o_d;
      vs_o_q  <= vs_o_d;
    end
  end

  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign de_req      = s1_q.de;
  assign frame_start = fs_q;
  assign vga_r       = rgb_q[3:0];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[11:8];
  assign vga_de      = de_o_q;
  assign vga_hs      = hs_o_q;
  assign vga_vs      = vs_o_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: two reduced rasters (latency 1 and 3) and
// the full 640x480 raster, checked cycle by cycle against a raster model.
module tb_vga_timing_ctrl;

  localparam int HA [3]  = '{40, 40, 640};
  localparam int HF [3]  = '{4, 4, 16};
  localparam int HSW [3] = '{8, 8, 96};
  localparam int HB [3]  = '{6, 6, 48};
  localparam int VA [3]  = '{12, 12, 480};
  localparam int VF [3]  = '{2, 2, 10};
  localparam int VSW [3] = '{2, 2, 2};
  localparam int VB [3]  = '{3, 3, 33};
  localparam int LAT [3] = '{1, 3, 1};
  localparam int FR = 58 * 19;
  localparam int MAXF = 8;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        dr;
    logic        fs;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  xp [3];
  logic [9:0]  yp [3];
  logic        dr [3], fs [3], hs [3], vs [3], de [3];
  logic [3:0]  r [3], g [3], b [3];
  logic [11:0] pd [3];
  obs_t        obs [3];

  int errors = 0;
  int checks = 0;
  int k;

  vga_timing_ctrl #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b0), .PIX_LAT(1)
  ) dut_a (
    .vga_clk(clk), .vga_rst(rst),
    .x_pos(xp[0]), .y_pos(yp[0]), .de_req(dr[0]),
    .frame_start(fs[0]), .pixel_data(pd[0]),
    .vga_r(r[0]), .vga_g(g[0]), .vga_b(b[0]),
    .vga_hs(hs[0]), .vga_vs(vs[0]), .vga_de(de[0])
  );

  vga_timing_ctrl #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b0), .PIX_LAT(3)
  ) dut_b (
    .vga_clk(clk), .vga_rst(rst),
    .x_pos(xp[1]), .y_pos(yp[1]), .de_req(dr[1]),
    .frame_start(fs[1]), .pixel_data(pd[1]),
    .vga_r(r[1]), .vga_g(g[1]), .vga_b(b[1]),
    .vga_hs(hs[1]), .vga_vs(vs[1]), .vga_de(de[1])
  );

  vga_timing_ctrl dut_f (
    .vga_clk(clk), .vga_rst(rst),
    .x_pos(xp[2]), .y_pos(yp[2]), .de_req(dr[2]),
    .frame_start(fs[2]), .pixel_data(pd[2]),
    .vga_r(r[2]), .vga_g(g[2]), .vga_b(b[2]),
    .vga_hs(hs[2]), .vga_vs(vs[2]), .vga_de(de[2])
  );

  for (genvar i = 0; i < 3; i++) begin : g_obs
    assign obs[i] = {de[i], hs[i], vs[i], b[i], g[i], r[i],
                     xp[i], yp[i], dr[i], fs[i]};
  end

  // Renderers return the column index; blanking returns junk.
  logic [11:0] blank = 12'hfff;
  logic [11:0] ra, rf;
  logic [11:0] rb0, rb1, rb2;
  always @(negedge clk)
    blank <= ($urandom_range(1) == 1) ? 12'hfff : 12'($urandom);
  always @(posedge clk) begin
    ra  <= dr[0] ? {2'b0, xp[0]} : blank;
    rf  <= dr[2] ? {2'b0, xp[2]} : blank;
    rb0 <= dr[1] ? {2'b0, xp[1]} : blank;
    rb1 <= rb0;
    rb2 <= rb1;
  end
  assign pd[0] = ra;
  assign pd[1] = rb2;
  assign pd[2] = rf;

  // Non-reset clocks since the last reset release.
  always @(posedge clk or posedge rst)
    if (rst) k <= 0;
    else     k <= k + 1;

  // Raster position of each signal group derived from elapsed clocks.
  function automatic obs_t model(int kk, int d);
    obs_t m;
    int ht, vt, q, h, v;
    bit act;
    ht = HA[d] + HF[d] + HSW[d] + HB[d];
    vt = VA[d] + VF[d] + VSW[d] + VB[d];
    m = '0;
    m.hs = 1'b1;
    m.vs = 1'b1;
    q = kk - 1;
    if (q >= 0) begin
      h = q % ht;
      v = (q / ht) % vt;
      act = (h < HA[d]) && (v < VA[d]);
      m.dr = act;
      m.x = act ? 10'(h) : 10'd0;
      m.y = act ? 10'(v) : 10'd0;
      m.fs = (h == 0) && (v == 0);
    end
    q = kk - LAT[d] - 2;
    if (q >= 0) begin
      h = q % ht;
      v = (q / ht) % vt;
      act = (h < HA[d]) && (v < VA[d]);
      m.de = act;
      m.hs = !((h >= HA[d] + HF[d]) && (h < HA[d] + HF[d] + HSW[d]));
      m.vs = !((v >= VA[d] + VF[d]) && (v < VA[d] + VF[d] + VSW[d]));
      m.rgb = act ? 12'(h) : 12'h0;
    end
    return m;
  endfunction

  task automatic test_reset();
    obs_t e;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      e = model(k, d);
      checks++;
      if (obs[d] !== e) begin
        errors++;
        $display("FAIL reset dut%0d got=%h exp=%h", d, obs[d], e);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_free_run(int n);
    obs_t e;
    int nf = 0;
    for (int c = 0; c < n && nf < MAXF; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        e = model(k, d);
        checks++;
        if (obs[d] !== e) begin
          errors++;
          nf++;
          $display("FAIL free_run dut%0d k=%0d got=%h exp=%h",
                   d, k, obs[d], e);
        end
      end
    end
  endtask

  task automatic test_frame_stats(int d);
    int ht, vt, t, lastfall, nvs, nde, nfs, nhs, nhsf;
    logic pde, phs, pvs;
    bit seen;
    ht = HA[d] + HF[d] + HSW[d] + HB[d];
    vt = VA[d] + VF[d] + VSW[d] + VB[d];
    seen = 0;
    for (int c = 0; c < 2 * FR && !seen; c++) begin
      @(negedge clk);
      seen = fs[d];
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL fs_wait dut%0d got=0 exp=1", d);
      return;
    end
    nvs = 0; nde = 0; nfs = 0; nhs = 0; nhsf = 0;
    lastfall = -1000000;
    pde = de[d]; phs = hs[d]; pvs = vs[d];
    for (t = 0; t < FR; t++) begin
      if (t > 0) @(negedge clk);
      nvs += int'(!vs[d]);
      nde += int'(de[d]);
      nfs += int'(fs[d]);
      nhs += int'(!hs[d]);
      if (pde && !de[d]) lastfall = t;
      if (phs && !hs[d]) begin
        nhsf++;
        if (t - lastfall < ht) begin
          checks++;
          if (t - lastfall !== HF[d]) begin
            errors++;
            $display("FAIL hs_after_de dut%0d got=%0d exp=%0d",
                     d, t - lastfall, HF[d]);
          end
        end
      end
      if (pvs && !vs[d]) begin
        checks++;
        if (t - lastfall !== (VF[d] + 1) * ht - HA[d]) begin
          errors++;
          $display("FAIL vs_after_de dut%0d got=%0d exp=%0d",
                   d, t - lastfall, (VF[d] + 1) * ht - HA[d]);
        end
      end
      pde = de[d]; phs = hs[d]; pvs = vs[d];
    end
    checks += 5;
    if (nvs !== VSW[d] * ht) begin
      errors++;
      $display("FAIL vs_low dut%0d got=%0d exp=%0d", d, nvs, VSW[d] * ht);
    end
    if (nde !== HA[d] * VA[d]) begin
      errors++;
      $display("FAIL de_count dut%0d got=%0d exp=%0d", d, nde, HA[d] * VA[d]);
    end
    if (nfs !== 1) begin
      errors++;
      $display("FAIL fs_count dut%0d got=%0d exp=1", d, nfs);
    end
    if (nhs !== HSW[d] * vt) begin
      errors++;
      $display("FAIL hs_low dut%0d got=%0d exp=%0d", d, nhs, HSW[d] * vt);
    end
    if (nhsf !== vt) begin
      errors++;
      $display("FAIL hs_lines dut%0d got=%0d exp=%0d", d, nhsf, vt);
    end
  endtask

  task automatic test_mid_reset();
    obs_t e;
    int tx, ty, nf;
    bit hit;
    tx = $urandom_range(0, 39);
    ty = $urandom_range(0, 11);
    hit = 0;
    for (int c = 0; c < FR + 10 && !hit; c++) begin
      @(negedge clk);
      hit = dr[0] && (xp[0] == 10'(tx)) && (yp[0] == 10'(ty));
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_pos_wait got=0 exp=1");
      return;
    end
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      e = model(k, d);
      checks++;
      if (obs[d] !== e) begin
        errors++;
        $display("FAIL async_reset dut%0d got=%h exp=%h", d, obs[d], e);
      end
    end
    nf = 0;
    for (int c = 0; c < 3 + 80 + int'($urandom_range(0, 40)); c++) begin
      @(negedge clk);
      for (int d = 0; d < 3 && nf < MAXF; d++) begin
        e = model(k, d);
        checks++;
        if (obs[d] !== e) begin
          errors++;
          nf++;
          $display("FAIL mid_reset dut%0d k=%0d got=%h exp=%h",
                   d, k, obs[d], e);
        end
      end
      if (c == 2) rst = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_free_run(2 * FR + 60);
    test_frame_stats(0);
    test_frame_stats(1);
    for (int i = 0; i < 3; i++) test_mid_reset();
    test_free_run(FR + 40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
